// File: rtl/vend_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vend_sequencer
// Purpose  : Vending transaction FSM: coin credit, price check, dispense,
//            unit-by-unit change payout and running sales total.
// Revision : 1.0 - initial release
// ============================================================================
module vend_sequencer #(
    parameter int MAX_CREDIT   = 20,
    parameter int TIMEOUT_S    = 30,
    parameter int DISPENSE_CYC = 4,
    parameter int ALARM_CYC    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       coin_valid,
    input  logic [3:0] coin_value,
    input  logic       confirm,
    input  logic       cancel,
    input  logic [3:0] product_code,
    input  logic       clear_sales,
    output logic [4:0] credit,
    output logic       coin_accept,
    output logic       coin_reject,
    output logic       alarm,
    output logic       product_dispensed,
    output logic       change_pulse,
    output logic [7:0] sales_total,
    output logic       busy,
    output logic [2:0] state
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_collect  = 3'd1;
    localparam logic [2:0] c_st_check    = 3'd2;
    localparam logic [2:0] c_st_alarm    = 3'd3;
    localparam logic [2:0] c_st_dispense = 3'd4;
    localparam logic [2:0] c_st_payout   = 3'd5;

    localparam int c_tmo_w   = $clog2(TIMEOUT_S + 1);
    localparam int c_cyc_max = (DISPENSE_CYC > ALARM_CYC) ? DISPENSE_CYC : ALARM_CYC;
    localparam int c_cyc_w   = $clog2(c_cyc_max + 1);

    localparam logic [c_tmo_w-1:0] c_tmo_limit  = c_tmo_w'(TIMEOUT_S);
    localparam logic [c_cyc_w-1:0] c_disp_last  = c_cyc_w'(DISPENSE_CYC - 1);
    localparam logic [c_cyc_w-1:0] c_alarm_last = c_cyc_w'(ALARM_CYC - 1);
    localparam logic [5:0]         c_max_credit = 6'(MAX_CREDIT);

    logic [2:0]         state_q, state_d;
    logic [4:0]         credit_q, credit_d;
    logic [7:0]         sales_q, sales_d;
    logic [c_tmo_w-1:0] tmo_q, tmo_d;
    logic [c_cyc_w-1:0] cyc_q, cyc_d;
    logic [3:0]         code_q, code_d;
    logic               coin_accept_q, coin_accept_d;
    logic               coin_reject_q, coin_reject_d;
    logic               alarm_q, alarm_d;
    logic               dispensed_q, dispensed_d;
    logic               change_q, change_d;
    logic               busy_q, busy_d;

    logic [5:0] w_coin_sum;
    logic       w_coin_legal;
    logic       w_open;
    logic       w_coin_ok;
    logic [4:0] w_price;
    logic       w_sale_ok;

    always_comb begin
        w_coin_sum   = {1'b0, credit_q} + {2'b00, coin_value};
        w_coin_legal = (coin_value == 4'd1) || (coin_value == 4'd2) || (coin_value == 4'd5);
        w_open       = (state_q == c_st_idle) || (state_q == c_st_collect);
        // A coin colliding with confirm/cancel in COLLECT loses to them.
        w_coin_ok    = coin_valid && w_open && w_coin_legal && (w_coin_sum <= c_max_credit) &&
                       !((state_q == c_st_collect) && (confirm || cancel));
        w_price      = {2'b00, code_q[2:0]} + 5'd1;
        w_sale_ok    = !code_q[3] && (credit_q >= w_price);
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        sales_d  = clear_sales ? 8'd0 : sales_q;
        tmo_d    = '0;
        cyc_d    = '0;
        code_d   = code_q;

        if (w_coin_ok) begin
            credit_d = w_coin_sum[4:0];
        end

        case (state_q)
            c_st_idle: begin
                if (w_coin_ok) begin
                    state_d = c_st_collect;
                end
            end
            c_st_collect: begin
                if (cancel) begin
                    state_d = c_st_payout;
                end else if (confirm) begin
                    code_d  = product_code;
                    state_d = c_st_check;
                end else begin
                    if (coin_valid) begin
                        tmo_d = '0;
                    end else if (sec_tick) begin
                        tmo_d = tmo_q + 1'b1;
                    end else begin
                        tmo_d = tmo_q;
                    end
                    if (tmo_d == c_tmo_limit) begin
                        tmo_d   = '0;
                        state_d = c_st_payout;
                    end
                end
            end
            c_st_check: begin
                if (w_sale_ok) begin
                    credit_d = credit_q - w_price;
                    sales_d  = sales_d + {3'b000, w_price};
                    state_d  = c_st_dispense;
                end else begin
                    state_d = c_st_alarm;
                end
            end
            c_st_alarm: begin
                if (cyc_q == c_alarm_last) begin
                    state_d = c_st_collect;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            c_st_dispense: begin
                if (cyc_q == c_disp_last) begin
                    state_d = (credit_q != 5'd0) ? c_st_payout : c_st_idle;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            c_st_payout: begin
                // The last unit is paid in the cycle whose exit lands in IDLE.
                if (credit_q > 5'd1) begin
                    credit_d = credit_q - 5'd1;
                end else begin
                    credit_d = 5'd0;
                    state_d  = c_st_idle;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase

        coin_accept_d = w_coin_ok;
        coin_reject_d = coin_valid && !w_coin_ok;
        alarm_d       = (state_d == c_st_alarm);
        dispensed_d   = (state_d == c_st_dispense);
        change_d      = (state_d == c_st_payout);
        busy_d        = !((state_d == c_st_idle) || (state_d == c_st_collect));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= c_st_idle;
            credit_q      <= '0;
            sales_q       <= '0;
            tmo_q         <= '0;
            cyc_q         <= '0;
            code_q        <= '0;
            coin_accept_q <= 1'b0;
            coin_reject_q <= 1'b0;
            alarm_q       <= 1'b0;
            dispensed_q   <= 1'b0;
            change_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            sales_q       <= sales_d;
            tmo_q         <= tmo_d;
            cyc_q         <= cyc_d;
            code_q        <= code_d;
            coin_accept_q <= coin_accept_d;
            coin_reject_q <= coin_reject_d;
            alarm_q       <= alarm_d;
            dispensed_q   <= dispensed_d;
            change_q      <= change_d;
            busy_q        <= busy_d;
        end
    end

    assign credit            = credit_q;
    assign coin_accept       = coin_accept_q;
    assign coin_reject       = coin_reject_q;
    assign alarm             = alarm_q;
    assign product_dispensed = dispensed_q;
    assign change_pulse      = change_q;
    assign sales_total       = sales_q;
    assign busy              = busy_q;
    assign state             = state_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_sequencer
// Purpose  : Self-checking bench for vend_sequencer; coin responses are
//            scoreboarded, transaction sequencing is checked per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sec_tick = 1'b0;
    logic       coin_valid = 1'b0;
    logic [3:0] coin_value = 4'd0;
    logic       confirm = 1'b0;
    logic       cancel = 1'b0;
    logic [3:0] product_code = 4'd0;
    logic       clear_sales = 1'b0;
    logic [4:0] credit;
    logic       coin_accept;
    logic       coin_reject;
    logic       alarm;
    logic       product_dispensed;
    logic       change_pulse;
    logic [7:0] sales_total;
    logic       busy;
    logic [2:0] state;

    typedef struct {
        int         due;
        logic       acc;
        logic       rej;
        logic [4:0] credit;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         m_credit = 0;
    logic [7:0] m_sales = 8'd0;

    vend_sequencer #(
        .MAX_CREDIT  (20),
        .TIMEOUT_S   (30),
        .DISPENSE_CYC(4),
        .ALARM_CYC   (8)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .sec_tick         (sec_tick),
        .coin_valid       (coin_valid),
        .coin_value       (coin_value),
        .confirm          (confirm),
        .cancel           (cancel),
        .product_code     (product_code),
        .clear_sales      (clear_sales),
        .credit           (credit),
        .coin_accept      (coin_accept),
        .coin_reject      (coin_reject),
        .alarm            (alarm),
        .product_dispensed(product_dispensed),
        .change_pulse     (change_pulse),
        .sales_total      (sales_total),
        .busy             (busy),
        .state            (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Coin response scoreboard: each coin expects its result one cycle later.
    always begin
        @(negedge clk);
        #1;
        if (sb.size() != 0 && sb[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL coin_resp_missing: due cycle %0d, now %0d", sb[0].due, cyc);
            sb.delete(0);
        end else if (sb.size() != 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if ({coin_accept, coin_reject, credit} !== {mon_e.acc, mon_e.rej, mon_e.credit}) begin
                errors++;
                $display("FAIL coin_resp: got acc=%b rej=%b credit=%0d, expected acc=%b rej=%b credit=%0d",
                         coin_accept, coin_reject, credit, mon_e.acc, mon_e.rej, mon_e.credit);
            end
        end else if (coin_accept || coin_reject) begin
            checks++;
            errors++;
            $display("FAIL coin_resp_unexpected: acc=%b rej=%b at cycle %0d", coin_accept, coin_reject, cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic coin(input int v, input bit bsy);
        exp_t x;
        bit   ok;
        ok = !bsy && (v == 1 || v == 2 || v == 5) && (m_credit + v <= 20);
        if (ok) m_credit += v;
        x.due    = cyc + 1;
        x.acc    = ok;
        x.rej    = !ok;
        x.credit = 5'(m_credit);
        sb.push_back(x);
        coin_value = 4'(v);
        coin_valid = 1'b1;
        @(negedge clk);
        coin_valid = 1'b0;
    endtask

    task automatic run_to_idle(output int pulses, output bit ok, output bit disp_seen);
        pulses    = 0;
        ok        = 1'b0;
        disp_seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (state === 3'd0) begin
                ok = 1'b1;
                break;
            end
            if (change_pulse === 1'b1) pulses++;
            if (product_dispensed === 1'b1) disp_seen = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({credit, coin_accept, coin_reject, alarm, product_dispensed, change_pulse,
             sales_total, busy, state} !== 22'd0) begin
            errors++;
            $display("FAIL reset_state: credit=%0d state=%0d sales=%0d busy=%b, expected all 0",
                     credit, state, sales_total, busy);
        end
        m_credit = 0;
        m_sales  = 8'd0;
    endtask

    task automatic test_purchase;
        int n;
        bit ok, ds;
        coin(5, 0);
        coin(2, 0);
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL purchase_collect: state=%0d expected 1", state); end
        product_code = 4'd3;
        confirm = 1'b1;
        @(negedge clk);
        confirm = 1'b0;
        checks++;
        if (state !== 3'd2 || credit !== 5'd7 || busy !== 1'b1) begin
            errors++;
            $display("FAIL purchase_check: state=%0d credit=%0d busy=%b expected 2/7/1", state, credit, busy);
        end
        @(negedge clk);
        m_credit -= 4;
        m_sales  += 8'd4;
        checks++;
        if (credit !== 5'(m_credit) || sales_total !== m_sales || product_dispensed !== 1'b1) begin
            errors++;
            $display("FAIL purchase_sale: credit=%0d sales=%0d disp=%b expected %0d/%0d/1",
                     credit, sales_total, product_dispensed, m_credit, m_sales);
        end
        n = 0;
        for (int i = 0; i < 16 && product_dispensed === 1'b1; i++) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 4) begin errors++; $display("FAIL dispense_len: got %0d cycles expected 4", n); end
        checks++;
        if (state !== 3'd5 || change_pulse !== 1'b1) begin
            errors++;
            $display("FAIL payout_start: state=%0d change=%b expected 5/1", state, change_pulse);
        end
        run_to_idle(n, ok, ds);
        m_credit = 0;
        checks++;
        if (!ok || n !== 3 || credit !== 5'd0 || sales_total !== 8'd4) begin
            errors++;
            $display("FAIL purchase_payout: idle=%b pulses=%0d credit=%0d sales=%0d expected 1/3/0/4",
                     ok, n, credit, sales_total);
        end
    endtask

    task automatic test_alarm;
        int n;
        coin(2, 0);
        for (int k = 0; k < 2; k++) begin
            product_code = (k == 0) ? 4'd6 : 4'd9;
            confirm = 1'b1;
            @(negedge clk);
            confirm = 1'b0;
            @(negedge clk);
            checks++;
            if (alarm !== 1'b1 || state !== 3'd3 || busy !== 1'b1) begin
                errors++;
                $display("FAIL alarm_rise[%0d]: alarm=%b state=%0d busy=%b expected 1/3/1", k, alarm, state, busy);
            end
            n = 0;
            for (int i = 0; i < 32 && alarm === 1'b1; i++) begin
                n++;
                @(negedge clk);
            end
            checks++;
            if (n !== 8 || state !== 3'd1 || credit !== 5'd2 || sales_total !== m_sales) begin
                errors++;
                $display("FAIL alarm_done[%0d]: len=%0d state=%0d credit=%0d sales=%0d expected 8/1/2/%0d",
                         k, n, state, credit, sales_total, m_sales);
            end
        end
    endtask

    task automatic test_cancel_confirm;
        int n;
        bit ok, ds;
        product_code = 4'd0;
        cancel  = 1'b1;
        confirm = 1'b1;
        @(negedge clk);
        cancel  = 1'b0;
        confirm = 1'b0;
        checks++;
        if (state !== 3'd5 || change_pulse !== 1'b1) begin
            errors++;
            $display("FAIL cancel_prio: state=%0d change=%b expected 5/1", state, change_pulse);
        end
        run_to_idle(n, ok, ds);
        m_credit = 0;
        checks++;
        if (!ok || n !== 2 || ds || sales_total !== m_sales) begin
            errors++;
            $display("FAIL cancel_refund: idle=%b pulses=%0d disp=%b sales=%0d expected 1/2/0/%0d",
                     ok, n, ds, sales_total, m_sales);
        end
    endtask

    task automatic test_max_credit;
        int n;
        bit ok, ds;
        for (int i = 0; i < 4; i++) coin(5, 0);
        coin(1, 0);
        coin(3, 0);
        @(negedge clk);
        checks++;
        if (credit !== 5'd20) begin errors++; $display("FAIL max_credit: credit=%0d expected 20", credit); end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        run_to_idle(n, ok, ds);
        m_credit = 0;
        checks++;
        if (!ok || n !== 20) begin errors++; $display("FAIL max_refund: idle=%b pulses=%0d expected 1/20", ok, n); end
    endtask

    task automatic test_timeout;
        int n;
        bit ok, ds;
        coin(5, 0);
        coin(2, 0);
        for (int i = 0; i < 30; i++) begin
            sec_tick = 1'b1;
            @(negedge clk);
            sec_tick = 1'b0;
            if (i == 28) begin
                checks++;
                if (state !== 3'd1) begin errors++; $display("FAIL timeout_early: state=%0d expected 1", state); end
            end
        end
        checks++;
        if (state !== 3'd5) begin errors++; $display("FAIL timeout_fire: state=%0d expected 5", state); end
        run_to_idle(n, ok, ds);
        m_credit = 0;
        checks++;
        if (!ok || n !== 7) begin errors++; $display("FAIL timeout_refund: idle=%b pulses=%0d expected 1/7", ok, n); end
    endtask

    task automatic test_busy_coin_and_reset;
        coin(5, 0);
        coin(2, 0);
        product_code = 4'd0;
        confirm = 1'b1;
        @(negedge clk);
        confirm = 1'b0;
        @(negedge clk);
        m_credit -= 1;
        m_sales  += 8'd1;
        coin(1, 1);
        @(negedge clk);
        checks++;
        if (credit !== 5'd6 || product_dispensed !== 1'b1) begin
            errors++;
            $display("FAIL busy_coin: credit=%0d disp=%b expected 6/1", credit, product_dispensed);
        end
        for (int i = 0; i < 16 && state !== 3'd5; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (state !== 3'd5 || change_pulse !== 1'b1) begin
            errors++;
            $display("FAIL reach_payout: state=%0d change=%b expected 5/1", state, change_pulse);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({credit, coin_accept, coin_reject, alarm, product_dispensed, change_pulse,
             sales_total, busy, state} !== 22'd0) begin
            errors++;
            $display("FAIL reset_in_payout: credit=%0d state=%0d sales=%0d change=%b, expected all 0",
                     credit, state, sales_total, change_pulse);
        end
        m_credit = 0;
        m_sales  = 8'd0;
    endtask

    task automatic buy(input int code);
        int rem, n;
        bit ok, ds;
        rem = code + 1;
        while (rem >= 5) begin coin(5, 0); rem -= 5; end
        while (rem >= 2) begin coin(2, 0); rem -= 2; end
        while (rem >= 1) begin coin(1, 0); rem -= 1; end
        product_code = 4'(code);
        confirm = 1'b1;
        @(negedge clk);
        confirm = 1'b0;
        @(negedge clk);
        m_credit -= code + 1;
        m_sales  += 8'(code + 1);
        run_to_idle(n, ok, ds);
        checks++;
        if (!ok || n !== 0 || sales_total !== m_sales || credit !== 5'(m_credit)) begin
            errors++;
            $display("FAIL buy[%0d]: idle=%b pulses=%0d sales=%0d credit=%0d expected 1/0/%0d/%0d",
                     code, ok, n, sales_total, credit, m_sales, m_credit);
        end
    endtask

    task automatic test_sales_wrap;
        for (int i = 0; i < 31; i++) buy(7);
        buy(5);
        checks++;
        if (sales_total !== 8'd254) begin errors++; $display("FAIL sales_254: got %0d expected 254", sales_total); end
        buy(3);
        checks++;
        if (sales_total !== 8'd2) begin errors++; $display("FAIL sales_wrap: got %0d expected 2", sales_total); end
    endtask

    task automatic test_clear_in_check;
        int n;
        bit ok, ds;
        coin(5, 0);
        product_code = 4'd4;
        confirm = 1'b1;
        @(negedge clk);
        confirm = 1'b0;
        clear_sales = 1'b1;
        @(negedge clk);
        clear_sales = 1'b0;
        m_credit = 0;
        m_sales  = 8'd5;
        checks++;
        if (sales_total !== 8'd5 || credit !== 5'd0) begin
            errors++;
            $display("FAIL clear_in_check: sales=%0d credit=%0d expected 5/0", sales_total, credit);
        end
        run_to_idle(n, ok, ds);
        checks++;
        if (!ok || n !== 0 || sales_total !== 8'd5) begin
            errors++;
            $display("FAIL clear_after: idle=%b pulses=%0d sales=%0d expected 1/0/5", ok, n, sales_total);
        end
    endtask

    initial begin
        test_reset();
        test_purchase();
        test_alarm();
        test_cancel_confirm();
        test_max_credit();
        test_timeout();
        test_busy_coin_and_reset();
        test_sales_wrap();
        test_clear_in_check();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vend_sequencer.md
# vend_sequencer

Transaction controller for the vending machine datapath. It accepts coin-insert events, accumulates credit, validates a product selection against a fixed price table, and drives the dispense strobe. It then pays out change one unit per cycle and keeps a running sales total. It sits between the front-panel button/coin logic and the display and dispense outputs, and replaces ad-hoc combinational change calculation with a single sequenced FSM.

## Interface
- MAX_CREDIT, 20, credit ceiling in coin units (must be ≤ 31)
- TIMEOUT_S, 30, idle seconds in COLLECT before automatic refund
- DISPENSE_CYC, 4, clock cycles `product_dispensed` is held high
- ALARM_CYC, 8, clock cycles `alarm` is held high per fault
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- sec_tick  in  1  one-cycle pulse per second from the clock divider
- coin_valid  in  1  one-cycle pulse: a coin is presented on `coin_value`
- coin_value  in  4  coin denomination; only 1, 2 and 5 are accepted
- confirm  in  1  one-cycle pulse: purchase `product_code`
- cancel  in  1  one-cycle pulse: abort and refund
- product_code  in  4  selection; 0–7 valid, price = code + 1
- clear_sales  in  1  one-cycle pulse: zero `sales_total`
- credit  out  5  current credit
- coin_accept / coin_reject  out  1 each  one-cycle result pulse per `coin_valid`
- alarm  out  1  invalid selection or insufficient credit
- product_dispensed  out  1  dispense strobe
- change_pulse  out  1  one pulse per coin unit returned
- sales_total  out  8  accumulated revenue, wraps modulo 256
- busy  out  1  high in every state except IDLE and COLLECT
- state  out  3  encoding: IDLE=0, COLLECT=1, CHECK=2, ALARM=3, DISPENSE=4, PAYOUT=5

## Operation
- All outputs are registered. On reset, every output and all internal registers are 0 and the FSM enters IDLE.
- Coin rule:
  - In IDLE or COLLECT, a coin is accepted if `coin_value` ∈ {1, 2, 5} and `credit + coin_value` ≤ MAX_CREDIT. An accepted coin adds to credit.
  - Otherwise `coin_reject` pulses and credit is unchanged.
  - Any `coin_valid` while `busy` is high is rejected.
- IDLE: an accepted coin moves the FSM to COLLECT. `confirm` and `cancel` are ignored.
- COLLECT:
  - `cancel` → PAYOUT.
  - else `confirm` → latch `product_code`, go to CHECK.
  - else timeout counter reaches TIMEOUT_S → PAYOUT.
  - The timeout counter clears on any `coin_valid` or `confirm` and increments on `sec_tick`.
- CHECK (exactly 1 cycle):
  - latched code > 7, or credit < price → ALARM.
  - otherwise `credit -= price`, `sales_total += price`, go to DISPENSE.
- ALARM: `alarm` is high for ALARM_CYC cycles, then the FSM returns to COLLECT with credit preserved and the timeout counter cleared.
- DISPENSE: `product_dispensed` is high for DISPENSE_CYC cycles, then → PAYOUT if credit > 0, else → IDLE.
- PAYOUT: each cycle `change_pulse` = 1 and `credit -= 1`. When credit reaches 0, `change_pulse` is low and the FSM goes to IDLE.
- Sales total: `clear_sales` zeroes it in any state. If it coincides with a CHECK sale, the result equals that sale's price.

## Timing
- `coin_accept`, `coin_reject` and the updated `credit` appear one cycle after `coin_valid`.
- Same-cycle priority in COLLECT: `cancel` > `confirm` > `coin_valid`. A coin arriving in the same cycle as `confirm` or `cancel` is rejected.
- Sequence from `confirm` at cycle T:
  - CHECK is entered at T+1.
  - `product_dispensed` or `alarm` rises at T+2.
  - `product_dispensed` falls at T+2+DISPENSE_CYC, which is also the first PAYOUT cycle.
- Payout takes exactly N cycles for a residual credit of N. IDLE is reached on cycle N+1.
- Reset asserted mid-transaction discards credit, aborts dispense and payout, and clears `sales_total` on the next edge.
- `sec_tick` is ignored outside COLLECT.

## Test plan
- Reset, then coins 5, 2; confirm code 3 (price 4) → credit goes 5, 7, then 3; `product_dispensed` is high for 4 cycles; 3 `change_pulse`s follow; `sales_total` = 4; FSM returns to IDLE.
- Credit 2, confirm code 6 (price 7) → `alarm` high for 8 cycles; FSM back to COLLECT; credit still 2; `sales_total` unchanged. Then confirm code 9 → ALARM again.
- Coins 5, 5, 5, 5, then 1 (MAX_CREDIT = 20) → the fifth coin gives `coin_reject`, credit = 20. A coin with value 3 → `coin_reject`.
- Credit 7 with no activity for 30 `sec_tick`s → PAYOUT with exactly 7 `change_pulse`s. Separately, `cancel` and `confirm` in the same cycle → refund only, no dispense.
- Coin during DISPENSE → `coin_reject` and credit unchanged. `rst` during PAYOUT → all outputs 0 on the next cycle.
- `sales_total` = 254, buy code 3 → wraps to 2. `clear_sales` in the CHECK cycle of a price-5 sale → `sales_total` = 5.
